// File: rtl/flag_unit_if.sv
// Bundle between the EX/ID pipeline stages and the flag unit: EX writer info,
// the ID branch instruction, and the flag results.
interface flag_unit_if;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic        ex_flush;
  logic        stall_in;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic [15:0] id_instruction;
  logic [2:0]  flags_stored;
  logic [2:0]  flags_fwd;
  logic        flag_stall;
  logic        flag_wr;

  modport master (
    output ex_valid, ex_opcode, ex_flush, stall_in, alu_result, alu_ovfl, id_instruction,
    input  flags_stored, flags_fwd, flag_stall, flag_wr
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_flush, stall_in, alu_result, alu_ovfl, id_instruction,
    output flags_stored, flags_fwd, flag_stall, flag_wr
  );
endinterface

// File: rtl/flag_unit.sv
// {N,Z,V} condition-flag register with branch hazard handling.
// Define FLAG_UNIT_FWD_EN to forward EX flags to the ID branch instead of stalling.
module flag_unit (
  input  logic         clk,
  input  logic         rst_n,
  flag_unit_if.slave   bus
);

  logic [2:0] r_flags;
  logic       r_flag_wr;

  logic       w_writer_nzv;
  logic       w_writer_z;
  logic       w_ex_live;
  logic       w_commit;
  logic       w_branch;
  logic       w_hazard;
  logic       w_n;
  logic       w_z;
  logic       w_v;
  logic [2:0] w_next_flags;
  logic       w_unused_id_bits;

  always_comb begin
    w_writer_nzv = 1'b0;
    w_writer_z   = 1'b0;
    case (bus.ex_opcode)
      4'b0000, 4'b0001:                   w_writer_nzv = 1'b1;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: w_writer_z   = 1'b1;
      default: ;
    endcase
  end

  assign w_n = bus.alu_result[15];
  assign w_z = (bus.alu_result == 16'h0000);
  assign w_v = bus.alu_ovfl;

  // Z-only writers keep the stored N and V.
  always_comb begin
    w_next_flags = r_flags;
    if (w_writer_nzv)
      w_next_flags = {w_n, w_z, w_v};
    else if (w_writer_z)
      w_next_flags = {r_flags[2], w_z, r_flags[0]};
  end

  assign w_ex_live = bus.ex_valid & ~bus.ex_flush;
  assign w_commit  = w_ex_live & ~bus.stall_in & (w_writer_nzv | w_writer_z);
  assign w_branch  = (bus.id_instruction[15:13] == 3'b110);
  assign w_hazard  = w_branch & w_ex_live & (w_writer_nzv | w_writer_z);
  assign w_unused_id_bits = ^bus.id_instruction[12:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= 3'b000;
      r_flag_wr <= 1'b0;
    end else begin
      if (w_commit)
        r_flags <= w_next_flags;
      r_flag_wr <= w_commit;
    end
  end

  assign bus.flags_stored = r_flags;
  assign bus.flag_wr      = r_flag_wr;

`ifdef FLAG_UNIT_FWD_EN
  // Reset gating keeps the combinational forward path quiet while rst_n is low.
  assign bus.flags_fwd  = !rst_n ? 3'b000 : (w_hazard ? w_next_flags : r_flags);
  assign bus.flag_stall = 1'b0;
`else
  assign bus.flags_fwd  = r_flags;
  assign bus.flag_stall = rst_n & w_hazard;
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit; expected values are hand-computed and
// selected for the forwarding or stalling build by FLAG_UNIT_FWD_EN.
module tb_flag_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  flag_unit_if bus();

  flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic fl, input logic st,
                       input logic [15:0] res, input logic ov, input logic [15:0] id);
    bus.ex_valid       = v;
    bus.ex_opcode      = op;
    bus.ex_flush       = fl;
    bus.stall_in       = st;
    bus.alu_result     = res;
    bus.alu_ovfl       = ov;
    bus.id_instruction = id;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  // advance past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] flags, input logic wr);
    check({tag, "_flags"}, {13'd0, bus.flags_stored}, {13'd0, flags});
    check({tag, "_wr"},    {15'd0, bus.flag_wr},      {15'd0, wr});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #3;
    check("rst_flags", {13'd0, bus.flags_stored}, 16'h0000);
    check("rst_wr",    {15'd0, bus.flag_wr},      16'h0000);
    check("rst_fwd",   {13'd0, bus.flags_fwd},    16'h0000);
    check("rst_stall", {15'd0, bus.flag_stall},   16'h0000);
    #4 rst_n = 1'b1;
    step();

    // SUB 8000, overflow -> N=1 Z=0 V=1
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h0000);
    step();
    chk_reg("sub", 3'b101, 1'b1);
    idle();
    step();
    chk_reg("sub_hold", 3'b101, 1'b0);

    // XOR zero -> Z set, N/V kept
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_reg("xor_z", 3'b111, 1'b1);
    idle();

    // async reset in the middle of a cycle, no edge
    #2 rst_n = 1'b0;
    #1;
    chk_reg("async_rst", 3'b000, 1'b0);

    // commit requested while in reset must wait for rst_n high
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h0000);
    step();
    chk_reg("in_rst", 3'b000, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk_reg("post_rst", 3'b101, 1'b1);

    // back-to-back Z-only writers
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_reg("xor0", 3'b111, 1'b1);
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h0000);
    step();
    chk_reg("xor1", 3'b101, 1'b1);

    // non-writer opcode
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_reg("nonwr", 3'b101, 1'b0);

    // flushed ADD with branch in ID: no commit, no hazard
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hC200);
    #1;
    check("flush_stall", {15'd0, bus.flag_stall}, 16'h0000);
    check("flush_fwd",   {13'd0, bus.flags_fwd},  16'h0005);
    step();
    chk_reg("flush", 3'b101, 1'b0);

    // stalled ADD held two cycles, commits when stall drops
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_reg("stall1", 3'b101, 1'b0);
    step();
    chk_reg("stall2", 3'b101, 1'b0);
    bus.stall_in = 1'b0;
    step();
    chk_reg("unstall", 3'b010, 1'b1);

    // clear to 000, then hazard: EX ADD result 0, ID branch C200
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0000);
    step();
    chk_reg("clear", 3'b000, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hC200);
    #1;
`ifdef FLAG_UNIT_FWD_EN
    check("haz_fwd",   {13'd0, bus.flags_fwd},  16'h0002);
    check("haz_stall", {15'd0, bus.flag_stall}, 16'h0000);
`else
    check("haz_fwd",   {13'd0, bus.flags_fwd},  16'h0000);
    check("haz_stall", {15'd0, bus.flag_stall}, 16'h0001);
`endif
    step();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hC200);
    #1;
    check("haz2_fwd",   {13'd0, bus.flags_fwd},  16'h0002);
    check("haz2_stall", {15'd0, bus.flag_stall}, 16'h0000);
    chk_reg("haz2", 3'b010, 1'b1);

    // Z-only hazard: stored 010, ROR result 8001 -> merged 000
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 16'h8001, 1'b1, 16'hC000);
    #1;
`ifdef FLAG_UNIT_FWD_EN
    check("zhaz_fwd",   {13'd0, bus.flags_fwd},  16'h0000);
    check("zhaz_stall", {15'd0, bus.flag_stall}, 16'h0000);
`else
    check("zhaz_fwd",   {13'd0, bus.flags_fwd},  16'h0002);
    check("zhaz_stall", {15'd0, bus.flag_stall}, 16'h0001);
`endif
    // same writer, ID not a branch (111x) -> no hazard
    bus.id_instruction = 16'hE000;
    #1;
    check("nobr_stall", {15'd0, bus.flag_stall}, 16'h0000);
    check("nobr_fwd",   {13'd0, bus.flags_fwd},  16'h0002);
    step();
    chk_reg("ror", 3'b000, 1'b1);

    // last writer wins: SUB 8000 -> 100, then ADD 0 ovfl -> 011
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 16'h8000, 1'b0, 16'h0000);
    step();
    chk_reg("b2b1", 3'b100, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    step();
    chk_reg("b2b2", 3'b011, 1'b1);
    idle();
    step();
    chk_reg("final", 3'b011, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
